// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The slave side is the subtractor; the master side is its producer/consumer.
interface serial_subtractor_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  in_bi;
  logic                  in_vld;
  logic                  in_rd;
  logic [DATA_WIDTH-1:0] out_d;
  logic                  out_bo;
  logic                  out_vld;
  logic                  out_rd;

  modport master (
    output in_a, in_b, in_bi, in_vld, out_rd,
    input  in_rd, out_d, out_bo, out_vld
  );

  modport slave (
    input  in_a, in_b, in_bi, in_vld, out_rd,
    output in_rd, out_d, out_bo, out_vld
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bi, one bit per clock,
// through a single full-subtractor cell and a borrow flop.
module serial_subtractor #(
  parameter int DATA_WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_sa;
  logic [DATA_WIDTH-1:0] r_sb;
  logic [DATA_WIDTH-1:0] r_d;
  logic                  r_br;
  logic [CW-1:0]         r_cnt;

  logic                  w_x;
  logic                  w_y;
  logic                  w_z;
  logic                  w_diff;
  logic                  w_bnext;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic [DATA_WIDTH-1:0] w_d_next;

  assign w_x = r_sa[0];
  assign w_y = r_sb[0];
  assign w_z = r_br;

  assign w_diff  = w_x ^ w_y ^ w_z;
  assign w_bnext = (~w_x & w_y) | (~(w_x ^ w_y) & w_z);

  // Difference bits enter at the MSB so bit i settles at position i.
  generate
    if (DATA_WIDTH == 1) begin : g_one
      assign w_d_next = w_diff;
    end else begin : g_many
      assign w_d_next = {w_diff, r_d[DATA_WIDTH-1:1]};
    end
  endgenerate

  assign bus.in_rd   = (r_state == S_IDLE);
  assign bus.out_vld = (r_state == S_DONE);
  assign bus.out_d   = r_d;
  assign bus.out_bo  = r_br;

  assign w_in_xfer  = bus.in_vld & bus.in_rd;
  assign w_out_xfer = bus.out_rd & bus.out_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_in_xfer) begin
            r_sa    <= bus.in_a;
            r_sb    <= bus.in_b;
            r_br    <= bus.in_bi;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_d   <= w_d_next;
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_br  <= w_bnext;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_out_xfer) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial ripple subtractor: computes d = a − b − bi over DATA_WIDTH bits with borrow-in and borrow-out, one bit per clock, using a single full-subtractor cell and a borrow flop. It is the subtraction and sequential counterpart of the team's combinational ripple adders. It trades area for latency in arithmetic datapaths that need a narrow footprint. Operands enter and results leave through handshaked (data/vld/rd) interfaces.

## Interface
- DATA_WIDTH, 4, operand and result width in bits; legal range is 1 or more.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_a  input  DATA_WIDTH  minuend.
- in_b  input  DATA_WIDTH  subtrahend.
- in_bi  input  1  borrow-in.
- in_vld  input  1  operand set valid.
- in_rd  output  1  block ready to accept operands.
- out_d  output  DATA_WIDTH  difference (a − b − bi) mod 2^DATA_WIDTH.
- out_bo  output  1  borrow-out; 1 when a < b + bi (unsigned).
- out_vld  output  1  result valid.
- out_rd  input  1  consumer ready.

## Operation
- Transfers:
  - An input transfer occurs on a clock edge where in_vld and in_rd are both 1.
  - An output transfer occurs on a clock edge where out_vld and out_rd are both 1.
- State machine has three states: IDLE, BUSY, DONE.
  - IDLE: in_rd = 1, out_vld = 0. On an input transfer:
    - latch in_a and in_b into the shift registers sa and sb;
    - set borrow register br = in_bi and bit counter cnt = 0;
    - move to BUSY.
  - BUSY: in_rd = 0, out_vld = 0. Each cycle the cell works on x = sa[0], y = sb[0], z = br:
    - difference bit = x ^ y ^ z;
    - next borrow = (~x & y) | (~(x ^ y) & z).
  - BUSY register updates each cycle:
    - shift the difference bit into the result register from the MSB end (logical shift right), so bit i lands at position i after DATA_WIDTH shifts;
    - shift sa and sb right by one;
    - br takes the next borrow; cnt increments.
  - BUSY exit: on the cycle where cnt = DATA_WIDTH−1, move to DONE. out_d then holds the full result and out_bo = br.
  - DONE: out_vld = 1, in_rd = 0. out_d and out_bo stay stable until the output transfer, then the block moves to IDLE.
- in_rd and out_vld are decoded combinationally from state only. They do not depend on in_vld or out_rd.
- in_a, in_b and in_bi are sampled only at the input transfer. Later changes have no effect.
- cnt width is max(1, ceil(log2(DATA_WIDTH))). For DATA_WIDTH = 1, BUSY lasts exactly one cycle.
- Reset, whether asserted mid-BUSY or mid-DONE:
  - state = IDLE; out_d = 0; out_bo = 0; out_vld = 0; in_rd = 1;
  - the in-flight operation is discarded and no result is emitted.
- Release from reset is synchronised by the surrounding design. The block requires no extra idle cycles after reset.

## Timing
- Input transfer at edge T0. BUSY covers edges T1..T_DATA_WIDTH.
- out_vld rises after edge T_DATA_WIDTH, so the latency is DATA_WIDTH cycles from acceptance to a valid result.
- If out_rd = 1 at the first out_vld edge, the block is in IDLE one cycle later.
- Minimum issue interval is DATA_WIDTH + 2 cycles. There is no overlap of operations.
- out_rd held low stalls the block in DONE indefinitely with outputs constant. No result is ever dropped or overwritten.
- in_vld asserted while in_rd = 0 is ignored. The producer must hold its data until in_rd is seen.

## Test plan
- DATA_WIDTH=4, a=5, b=3, bi=0 -> out_d=2, out_bo=0; out_vld rises 4 cycles after acceptance.
- a=3, b=5, bi=0 -> out_d=14, out_bo=1. Then a=0, b=0, bi=1 -> out_d=15, out_bo=1. Then a=15, b=15, bi=1 -> out_d=15, out_bo=1.
- Backpressure: a=9, b=4, bi=0 with out_rd low for 3 cycles after out_vld -> out_d=5 and out_bo=0 held constant; in_rd=0 throughout. A second in_vld pulse during the stall is not accepted.
- Back-to-back: in_vld held high with two operand sets, out_rd tied 1 -> second acceptance occurs exactly 6 cycles after the first; results are correct and in order.
- Reset asserted asynchronously on BUSY cycle 2 -> out_vld=0, out_d=0, out_bo=0 and in_rd=1 immediately. The next operation (a=1, b=1, bi=0 -> d=0, bo=0) completes normally.
- DATA_WIDTH=1 build: a=0, b=1, bi=0 -> d=1, bo=1, with 1-cycle latency. Randomised compare against (a − b − bi) mod 2^W for 1000 vectors.
